// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit unsigned adder split into STAGES chunk-wide stages with a
// registered carry between stages and valid/ready back-pressure. Optional ovf output: ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CHUNK = WIDTH / STAGES;

  logic              adv_s;
  logic [STAGES-1:0] v_r;

  assign adv_s     = !v_r[STAGES-1] || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = v_r[STAGES-1];

  // Valid bits shift as one unit; empty slots travel with the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= {STAGES{1'b0}};
    end else if (adv_s) begin
      v_r[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        v_r[i] <= v_r[i-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int REM  = WIDTH - k * CHUNK;  // operand bits still unadded on entry to stage k
    localparam int DONE = (k + 1) * CHUNK;    // finished sum bits held by stage k

    logic [REM-1:0]  opa_s;
    logic [REM-1:0]  opb_s;
    logic            cprev_s;
    logic [CHUNK:0]  add_s;
    logic [DONE-1:0] sum_nx_s;
    logic [DONE-1:0] sum_r;
    logic            c_r;

    assign add_s = {1'b0, opa_s[CHUNK-1:0]} + {1'b0, opb_s[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, cprev_s};

    if (k == 0) begin : src
      assign opa_s    = a;
      assign opb_s    = b;
      assign cprev_s  = cin;
      assign sum_nx_s = add_s[CHUNK-1:0];
    end else begin : src
      assign opa_s    = stg[k-1].opr.a_r;
      assign opb_s    = stg[k-1].opr.b_r;
      assign cprev_s  = stg[k-1].c_r;
      assign sum_nx_s = {add_s[CHUNK-1:0], stg[k-1].sum_r};
    end

    if (k < STAGES - 1) begin : opr
      logic [REM-CHUNK-1:0] a_r;
      logic [REM-CHUNK-1:0] b_r;

      // Upper operand bits ride along until their chunk's stage is reached.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= {(REM-CHUNK){1'b0}};
          b_r <= {(REM-CHUNK){1'b0}};
        end else if (adv_s) begin
          a_r <= opa_s[REM-1:CHUNK];
          b_r <= opb_s[REM-1:CHUNK];
        end
      end
    end

    // Partial sum and the carry handed to the next stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_r <= {DONE{1'b0}};
        c_r   <= 1'b0;
      end else if (adv_s) begin
        sum_r <= sum_nx_s;
        c_r   <= add_s[CHUNK];
      end
    end
  end

  assign sum   = stg[STAGES-1].sum_r;
  assign carry = stg[STAGES-1].c_r;

`ifdef ADDER_OVF_EN
  logic ovf_nx_s;
  logic ovf_r;

  // The last stage's operand chunk carries the original operand MSBs.
  assign ovf_nx_s = (stg[STAGES-1].opa_s[CHUNK-1] == stg[STAGES-1].opb_s[CHUNK-1])
                 && (stg[STAGES-1].add_s[CHUNK-1] != stg[STAGES-1].opa_s[CHUNK-1]);

  // Overflow flag registered alongside the final sum chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (adv_s) begin
      ovf_r <= ovf_nx_s;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed scenarios plus random traffic, checked
// against a queue-based reference of in-flight operations.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // One in-flight operation: expected result and the number of advancing edges it still needs.
  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int               left;
  } op_t;

  op_t              q[$];
  int               checks    = 0;
  int               errors    = 0;
  int               accepted  = 0;
  int               delivered = 0;
  logic [WIDTH-1:0] last_sum;
  logic             last_carry;
  logic             last_ovf;
  logic [WIDTH-1:0] held_sum;
  logic             held_carry;
  int               d0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, compare against the reference, update it for the coming edge.
  task automatic tick();
    logic           exp_v;
    logic [WIDTH:0] full;
    op_t            n;
    @(negedge clk);
    exp_v = (q.size() != 0) && (q[0].left == 0);
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("in_ready", 32'(in_ready), 32'(!exp_v || out_ready));
      if (exp_v) begin
        check("sum", 32'(sum), 32'(q[0].s));
        check("carry", 32'(carry), 32'(q[0].c));
`ifdef ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(q[0].o));
`endif
      end
    end
    if (rst) begin
      q.delete();
    end else if (!exp_v || out_ready) begin
      if (exp_v) begin
        last_sum   = sum;
        last_carry = carry;
`ifdef ADDER_OVF_EN
        last_ovf   = ovf;
`else
        last_ovf   = 1'b0;
`endif
        delivered++;
        void'(q.pop_front());
      end
      foreach (q[i]) begin
        if (q[i].left > 0) q[i].left = q[i].left - 1;
      end
      if (in_valid) begin
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        n.s    = full[WIDTH-1:0];
        n.c    = full[WIDTH];
        n.o    = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        n.left = STAGES - 1;
        q.push_back(n);
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic cc);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = cc;
    tick();
  endtask

  task automatic run_idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 16'h0000;
    b         = 16'h0000;
    cin       = 1'b0;
    last_sum  = 16'h0000;
    last_carry = 1'b0;
    last_ovf  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);

    // Carry ripple through every stage
    d0 = delivered;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    run_idle(3);
    check("ripple_not_early", 32'(delivered - d0), 32'd0);
    run_idle(1);
    check("ripple_count", 32'(delivered - d0), 32'd1);
    check("ripple_sum", 32'(last_sum), 32'h0000);
    check("ripple_carry", 32'(last_carry), 32'd1);

    // Carry-in only
    drive(1'b1, 16'h0000, 16'hFFFF, 1'b1);
    run_idle(4);
    check("cin_sum", 32'(last_sum), 32'h0000);
    check("cin_carry", 32'(last_carry), 32'd1);
    drive(1'b1, 16'h1234, 16'h4321, 1'b1);
    run_idle(4);
    check("cin2_sum", 32'(last_sum), 32'h5556);
    check("cin2_carry", 32'(last_carry), 32'd0);

    // Streaming: 8 back-to-back random pairs
    d0 = delivered;
    for (int i = 0; i < 8; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    run_idle(4);
    check("stream_count", 32'(delivered - d0), 32'd8);

    // Back-pressure with a full pipeline
    for (int i = 0; i < 4; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    check("bp_full_valid", 32'(out_valid), 32'd1);
    held_sum   = sum;
    held_carry = carry;
    out_ready  = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_sum_held", 32'(sum), 32'(held_sum));
    check("bp_carry_held", 32'(carry), 32'(held_carry));
    out_ready = 1'b1;
    run_idle(6);
    check("bp_no_loss", 32'(accepted - delivered), 32'd0);

    // Reset with 3 operations in flight
    for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_sum", 32'(sum), 32'd0);
    d0 = delivered;
    run_idle(6);
    check("mrst_no_stale", 32'(delivered - d0), 32'd0);
    drive(1'b1, 16'h00FF, 16'h0F01, 1'b0);
    run_idle(3);
    check("mrst_lat_early", 32'(delivered - d0), 32'd0);
    run_idle(1);
    check("mrst_lat", 32'(delivered - d0), 32'd1);
    check("mrst_sum_after", 32'(last_sum), 32'h1000);

`ifdef ADDER_OVF_EN
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    run_idle(4);
    check("ovf1", 32'(last_ovf), 32'd1);
    check("ovf1_carry", 32'(last_carry), 32'd0);
    drive(1'b1, 16'h8000, 16'h8000, 1'b0);
    run_idle(4);
    check("ovf2", 32'(last_ovf), 32'd1);
    check("ovf2_carry", 32'(last_carry), 32'd1);
    drive(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    run_idle(4);
    check("ovf3", 32'(last_ovf), 32'd0);
    check("ovf3_carry", 32'(last_carry), 32'd1);
`endif

    // Random traffic with stalls and occasional resets
    for (int i = 0; i < 120; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    run_idle(6);
    check("rand_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
